// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: round-robin writeback arbiter for the single regfile write port
// plus a 32-entry busy scoreboard that decode uses to stall on pending destinations.
module rf_wb_scheduler #(
    parameter int NUM_REQ = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*5-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic                  rf_we,
    output logic [4:0]            rf_rd_addr,
    output logic [31:0]           rf_rd_data,
    input  logic                  rsv_valid,
    input  logic [4:0]            rsv_addr,
    output logic                  rsv_ready,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [31:0]           busy_mask
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr, gnt_idx, cand;
    logic          gnt_any;
    logic [4:0]    addr_a [NUM_REQ];
    logic [31:0]   data_a [NUM_REQ];
    logic [4:0]    gnt_addr;
    logic [31:0]   gnt_data;
    logic [31:0]   busy, busy_nxt, clr, set;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign addr_a[i] = req_addr[5*i +: 5];
        assign data_a[i] = req_data[32*i +: 32];
    end

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign gnt_addr  = addr_a[gnt_idx];
    assign gnt_data  = data_a[gnt_idx];

    assign rsv_ready = !busy[rsv_addr] || rsv_addr == 5'd0;

    // Set is applied after clear so a reservation landing on a committing write wins.
    always_comb begin
        clr      = rf_we ? (32'd1 << rf_rd_addr) : 32'd0;
        set      = (rsv_valid && rsv_ready && rsv_addr != 5'd0) ? (32'd1 << rsv_addr) : 32'd0;
        busy_nxt = (busy & ~clr) | set;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= PW'(NUM_REQ - 1);
            rf_we      <= 1'b0;
            rf_rd_addr <= 5'd0;
            rf_rd_data <= 32'd0;
            busy       <= 32'd0;
        end else begin
            rf_we <= gnt_any && gnt_addr != 5'd0;
            if (gnt_any) begin
                ptr        <= gnt_idx;
                rf_rd_addr <= gnt_addr;
                rf_rd_data <= gnt_data;
            end
            busy <= busy_nxt;
        end
    end

    assign busy_mask = busy;
    assign rs1_busy  = busy[rs1_addr];
    assign rs2_busy  = busy[rs2_addr];
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed scenario tests for rf_wb_scheduler with hand-computed expectations.
module tb_rf_wb_scheduler;
    localparam int NUM_REQ = 3;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*5-1:0]  req_addr = '0;
    logic [NUM_REQ*32-1:0] req_data = '0;
    logic                  rf_we;
    logic [4:0]            rf_rd_addr;
    logic [31:0]           rf_rd_data;
    logic                  rsv_valid = 1'b0;
    logic [4:0]            rsv_addr = '0;
    logic                  rsv_ready;
    logic [4:0]            rs1_addr = '0;
    logic [4:0]            rs2_addr = '0;
    logic                  rs1_busy, rs2_busy;
    logic [31:0]           busy_mask;

    int checks = 0;
    int errors = 0;

    rf_wb_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_mask(busy_mask)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", rf_we); end
        checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", rf_rd_addr); end
        checks++; if (rf_rd_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", rf_rd_data); end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL rst_busy got %h exp 0", busy_mask); end
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        tick();
        req_valid = 3'b010; req_addr[5 +: 5] = 5'd3; req_data[32 +: 32] = 32'h55;
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        tick();
        req_valid = '0; rsv_valid = 1'b0;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL mid_we got %0b exp 1", rf_we); end
        checks++; if (busy_mask !== 32'h10) begin errors++; $display("FAIL mid_busy got %h exp 00000010", busy_mask); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL async_we got %0b exp 0", rf_we); end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL async_busy got %h exp 0", busy_mask); end
        checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL async_addr got %0d exp 0", rf_rd_addr); end
        @(negedge clock) reset_n = 1'b1;
        #1 req_valid = 3'b111;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL post_rst_prio got %b exp 001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy;
        tick();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[5*i +: 5]   = 5'(i + 1);
            req_data[32*i +: 32] = 32'hA0 + 32'(i);
        end
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            exp_rdy = 3'b001 << (c % 3);
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", c, req_ready, exp_rdy); end
            tick();
            if (c == 5) req_valid = '0;
            checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'((c % 3) + 1) || rf_rd_data !== 32'hA0 + 32'(c % 3)) begin
                errors++; $display("FAIL rr_write%0d got we=%0b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                                   c, rf_we, rf_rd_addr, rf_rd_data, (c % 3) + 1, 32'hA0 + 32'(c % 3));
            end
        end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rr_idle_we got %0b exp 0", rf_we); end
    endtask

    task automatic test_latency();
        req_valid = 3'b010; req_addr[5 +: 5] = 5'd5; req_data[32 +: 32] = 32'hDEADBEEF;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL lat_ready got %b exp 010", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd5 || rf_rd_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lat_write got we=%0b addr=%0d data=%h exp we=1 addr=5 data=deadbeef", rf_we, rf_rd_addr, rf_rd_data);
        end
        req_valid = 3'b011;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL lat_ptr got %b exp 001", req_ready); end
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL lat_noreq got %b exp 000", req_ready); end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_rd_addr !== 5'd5 || rf_rd_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lat_hold got we=%0b addr=%0d data=%h exp we=0 addr=5 data=deadbeef", rf_we, rf_rd_addr, rf_rd_data);
        end
    endtask

    task automatic test_x0_write();
        req_valid = 3'b100; req_addr[10 +: 5] = 5'd0; req_data[64 +: 32] = 32'h12345678;
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL x0_ready got %b exp 100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %0b exp 0", rf_we); end
    endtask

    task automatic test_scoreboard();
        rsv_valid = 1'b1; rsv_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd8;
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL sb_rsv_ready got %0b exp 1", rsv_ready); end
        tick();
        checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sb_busy7 got %h exp 00000080", busy_mask); end
        checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_rs got rs1=%0b rs2=%0b exp rs1=1 rs2=0", rs1_busy, rs2_busy); end
        checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL sb_rereserve got %0b exp 0", rsv_ready); end
        tick();
        rsv_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL sb_x0_ready got %0b exp 1", rsv_ready); end
        tick();
        rsv_valid = 1'b0;
        checks++; if (busy_mask !== 32'h80 || rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_x0_busy got %h rs2=%0b exp 00000080 rs2=0", busy_mask, rs2_busy); end
        req_valid = 3'b001; req_addr[0 +: 5] = 5'd7; req_data[0 +: 32] = 32'h77;
        tick();
        req_valid = '0; rsv_addr = 5'd7;
        #1;
        checks++; if (rf_we !== 1'b1 || busy_mask !== 32'h80 || rsv_ready !== 1'b0) begin
            errors++; $display("FAIL sb_commit got we=%0b busy=%h rsv_ready=%0b exp we=1 busy=00000080 rsv_ready=0", rf_we, busy_mask, rsv_ready);
        end
        tick();
        checks++; if (busy_mask !== 32'd0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear got %h rs1=%0b exp 0 rs1=0", busy_mask, rs1_busy); end
    endtask

    task automatic test_collision();
        req_valid = 3'b001; req_addr[0 +: 5] = 5'd9; req_data[0 +: 32] = 32'h99;
        tick();
        req_valid = '0; rsv_valid = 1'b1; rsv_addr = 5'd9;
        #1;
        checks++; if (rf_we !== 1'b1 || rsv_ready !== 1'b1) begin errors++; $display("FAIL col_setup got we=%0b rsv_ready=%0b exp 1 1", rf_we, rsv_ready); end
        tick();
        rsv_valid = 1'b0;
        checks++; if (busy_mask !== 32'h200) begin errors++; $display("FAIL col_set_wins got %h exp 00000200", busy_mask); end
        rsv_valid = 1'b1; rsv_addr = 5'd10;
        tick();
        rsv_valid = 1'b0;
        req_valid = 3'b001; req_addr[0 +: 5] = 5'd10;
        tick();
        req_valid = '0; rsv_valid = 1'b1; rsv_addr = 5'd10;
        #1;
        checks++; if (rf_we !== 1'b1 || rsv_ready !== 1'b0) begin errors++; $display("FAIL col_rsv_blocked got we=%0b rsv_ready=%0b exp 1 0", rf_we, rsv_ready); end
        tick();
        rsv_valid = 1'b0;
        checks++; if (busy_mask !== 32'h200) begin errors++; $display("FAIL col_clear10 got %h exp 00000200", busy_mask); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_latency();
        test_x0_write();
        test_scoreboard();
        test_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
